// File: rtl/sram_arb_ctrl_pkg.sv
// Shared definitions for the two-port SRAM arbiter/controller: defaults,
// requester count, controller states and the round-robin pointer update rule.
package sram_arb_ctrl_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int ADDR_W_DEF = 6;
    localparam int N_REQ      = 2;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // After a grant the priority moves to the port that was not served.
    function automatic logic ptr_after_grant(input logic [N_REQ-1:0] grant,
                                             input logic             ptr);
        logic nxt;
        if (grant[0]) begin
            nxt = 1'b1;
        end else if (grant[1]) begin
            nxt = 1'b0;
        end else begin
            nxt = ptr;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sram_arb_ctrl_rr_arb2.sv
// Two-way round-robin grant: ptr selects the winner only when both request.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    // one-hot grant selection
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Two-requester SRAM controller: zero-fills the array after reset, then
// arbitrates reads/posted writes round-robin, holding unaccepted read data.
module sram_arb_ctrl
    import sram_arb_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0]               req_write,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_wdata,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_wmask,
    output logic [N_REQ-1:0]               resp_valid,
    input  logic [N_REQ-1:0]               resp_ready,
    output logic [DATA_W-1:0]              resp_rdata,
    output logic                           sram_CEN,
    output logic                           sram_WEN,
    output logic [DATA_W-1:0]              sram_BWEN,
    output logic [ADDR_W-1:0]              sram_A,
    output logic [DATA_W-1:0]              sram_D,
    input  logic [DATA_W-1:0]              sram_Q,
    output logic                           init_done
);

    localparam logic [ADDR_W-1:0] INIT_LAST = {ADDR_W{1'b1}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                ptr_q, ptr_d;
    logic                pend_q, pend_d;
    logic                port_q, port_d;
    logic [DATA_W-1:0]   hold_q, hold_d;

    logic                resp_block_s;
    logic                arb_en_s;
    logic [N_REQ-1:0]    arb_req_s;
    logic [N_REQ-1:0]    grant_s;
    logic                sel_s;

    // A presented read response that is not taken this cycle blocks new grants.
    assign resp_block_s = pend_q & ~resp_ready[port_q];
    assign arb_en_s     = ~reset & (state_q == ST_RUN) & ~resp_block_s;
    assign arb_req_s    = req_valid & {N_REQ{arb_en_s}};
    assign sel_s        = grant_s[1];

    rr_arb2 u_arb (
        .req   (arb_req_s),
        .ptr   (ptr_q),
        .grant (grant_s)
    );

    // next-state and SRAM/handshake output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        pend_d     = 1'b0;
        port_d     = port_q;
        hold_d     = hold_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        resp_rdata = {DATA_W{1'b0}};
        sram_CEN   = 1'b1;
        sram_WEN   = 1'b1;
        sram_BWEN  = {DATA_W{1'b1}};
        sram_A     = {ADDR_W{1'b0}};
        sram_D     = {DATA_W{1'b0}};
        init_done  = 1'b0;
        if (reset) begin
            state_d = ST_INIT;
            cnt_d   = {ADDR_W{1'b0}};
        end else begin
            case (state_q)
                ST_INIT: begin
                    sram_CEN  = 1'b0;
                    sram_WEN  = 1'b0;
                    sram_BWEN = {DATA_W{1'b0}};
                    sram_A    = cnt_q;
                    cnt_d     = cnt_q + ADDR_W'(1);
                    if (cnt_q == INIT_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_INIT;
                    end
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    if (pend_q) begin
                        resp_valid[port_q] = 1'b1;
                        resp_rdata         = sram_Q;
                    end else begin
                        resp_valid = 2'b00;
                    end
                    if (resp_block_s) begin
                        state_d = ST_HOLD;
                        hold_d  = sram_Q;
                    end else if (|grant_s) begin
                        req_ready = grant_s;
                        sram_CEN  = 1'b0;
                        sram_A    = req_addr[sel_s];
                        ptr_d     = ptr_after_grant(grant_s, ptr_q);
                        port_d    = sel_s;
                        if (req_write[sel_s]) begin
                            sram_WEN  = 1'b0;
                            sram_BWEN = ~req_wmask[sel_s];
                            sram_D    = req_wdata[sel_s];
                        end else begin
                            pend_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    init_done          = 1'b1;
                    resp_valid[port_q] = 1'b1;
                    resp_rdata         = hold_q;
                    if (resp_ready[port_q]) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // state, init counter, arbitration pointer and response tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= {ADDR_W{1'b0}};
            ptr_q   <= 1'b0;
            pend_q  <= 1'b0;
            port_q  <= 1'b0;
            hold_q  <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            port_q  <= port_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Self-checking bench for sram_arb_ctrl: directed scenarios plus random traffic
// compared against a transaction-level memory/arbitration model.
module tb_sram_arb_ctrl;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam logic [DATA_W-1:0] ALL1   = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] MASK27 = {8'h00, {120{1'b1}}};
    localparam logic [DATA_W-1:0] D1234  = 128'h1234;
    localparam logic [DATA_W-1:0] D00AB  = 128'hAB;

    logic                         clock = 1'b0;
    logic                         reset;
    logic [1:0]                   req_valid, req_ready, req_write;
    logic [1:0][ADDR_W-1:0]       req_addr;
    logic [1:0][DATA_W-1:0]       req_wdata, req_wmask;
    logic [1:0]                   resp_valid, resp_ready;
    logic [DATA_W-1:0]            resp_rdata;
    logic                         sram_CEN, sram_WEN;
    logic [DATA_W-1:0]            sram_BWEN, sram_D, sram_Q;
    logic [ADDR_W-1:0]            sram_A;
    logic                         init_done;

    always #5 clock = ~clock;

    sram_arb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .sram_CEN(sram_CEN), .sram_WEN(sram_WEN), .sram_BWEN(sram_BWEN),
        .sram_A(sram_A), .sram_D(sram_D), .sram_Q(sram_Q), .init_done(init_done)
    );

    // synchronous single-port SRAM with active-low bit write enables
    logic [DATA_W-1:0] sram_mem [0:DEPTH-1];
    always @(posedge clock) begin
        if (!sram_CEN) begin
            if (!sram_WEN) sram_mem[sram_A] <= (sram_mem[sram_A] & sram_BWEN) | (sram_D & ~sram_BWEN);
            else           sram_Q <= sram_mem[sram_A];
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // transaction-level reference model
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    bit                m_pend, m_held;
    int                m_port, m_pref;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        exp_ready, exp_rvalid;
    logic [DATA_W-1:0] exp_rdata;
    int                exp_g;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        m_pend = 0; m_held = 0; m_port = 0; m_pref = 0; m_data = '0;
    endtask

    task automatic model_eval();
        bit can_grant;
        exp_rvalid = 2'b00; exp_rdata = '0; exp_ready = 2'b00; exp_g = -1;
        if (m_pend) begin
            exp_rvalid[m_port] = 1'b1;
            exp_rdata = m_data;
        end
        can_grant = !m_pend || (!m_held && resp_ready[m_port]);
        if (can_grant) begin
            if (req_valid == 2'b11)  exp_g = m_pref;
            else if (req_valid[0])   exp_g = 0;
            else if (req_valid[1])   exp_g = 1;
        end
        if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
    endtask

    task automatic model_commit();
        if (m_pend) begin
            if (resp_ready[m_port]) m_pend = 0;
            else                    m_held = 1;
        end
        if (!m_pend) m_held = 0;
        if (exp_g >= 0) begin
            m_pref = 1 - exp_g;
            if (req_write[exp_g]) begin
                ref_mem[req_addr[exp_g]] = (ref_mem[req_addr[exp_g]] & ~req_wmask[exp_g])
                                         | (req_wdata[exp_g] & req_wmask[exp_g]);
            end else begin
                m_pend = 1; m_held = 0; m_port = exp_g;
                m_data = ref_mem[req_addr[exp_g]];
            end
        end
    endtask

    task automatic set_idle();
        req_valid = 2'b00; req_write = 2'b00; resp_ready = 2'b11;
        req_addr = '0; req_wdata = '0; req_wmask = '0;
    endtask

    task automatic set_req(input int p, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
        req_valid[p] = 1'b1; req_write[p] = w; req_addr[p] = a;
        req_wdata[p] = d; req_wmask[p] = m;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_idle();
        req_valid = 2'b11;
        repeat (3) @(negedge clock);
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
        n_cmp++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 00", resp_valid); end
        n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        n_cmp++; if ({sram_CEN, sram_WEN} !== 2'b11) begin n_fail++; $display("FAIL rst_cen_wen: got %b want 11", {sram_CEN, sram_WEN}); end
        n_cmp++; if (sram_BWEN !== ALL1) begin n_fail++; $display("FAIL rst_bwen: got %h want all ones", sram_BWEN); end
        n_cmp++; if (resp_rdata !== '0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        @(negedge clock);
    endtask

    task automatic test_init();
        reset = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            n_cmp++;
            if (init_done !== 1'b0 || sram_CEN !== 1'b0 || sram_WEN !== 1'b0 || sram_A !== ADDR_W'(k)
                || sram_BWEN !== '0 || sram_D !== '0 || req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL init_cycle %0d: got done=%b cen=%b wen=%b a=%0d bwen0=%b d0=%b rdy=%b want 0,0,0,%0d,1,1,00",
                         k, init_done, sram_CEN, sram_WEN, sram_A, sram_BWEN == '0, sram_D == '0, req_ready, k);
            end
            @(negedge clock);
        end
        req_valid = 2'b00;
        #1;
        n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_rise: got %b want 1", init_done); end
        n_cmp++; if (sram_CEN !== 1'b1) begin n_fail++; $display("FAIL init_idle_cen: got %b want 1", sram_CEN); end
        model_reset();
        @(negedge clock);
    endtask

    task automatic test_wr_rd_fwd();
        for (int k = 0; k < 3; k++) begin
            set_idle();
            case (k)
                0:       set_req(1, 1'b1, 6'd9, D00AB, ALL1);
                1:       set_req(1, 1'b0, 6'd9, '0, '0);
                default: ;
            endcase
            model_eval();
            #1;
            n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL fwd_ready c%0d: got %b want %b", k, req_ready, exp_ready); end
            n_cmp++; if (resp_valid !== exp_rvalid) begin n_fail++; $display("FAIL fwd_rvalid c%0d: got %b want %b", k, resp_valid, exp_rvalid); end
            if (k == 2) begin
                n_cmp++; if (resp_rdata !== D00AB) begin n_fail++; $display("FAIL fwd_rdata: got %h want %h", resp_rdata, D00AB); end
            end
            model_commit();
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 11; k++) begin
            set_idle();
            if (k < 10) begin
                set_req(0, 1'b0, ADDR_W'($urandom_range(0, 15)), '0, '0);
                set_req(1, 1'b0, ADDR_W'($urandom_range(0, 15)), '0, '0);
                if (k == 0) req_addr[0] = 6'd9;
            end
            model_eval();
            #1;
            if (k < 10) begin
                n_cmp++;
                if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL b2b_alternate c%0d: got %b want %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            n_cmp++; if (resp_valid !== exp_rvalid) begin n_fail++; $display("FAIL b2b_rvalid c%0d: got %b want %b", k, resp_valid, exp_rvalid); end
            if (exp_rvalid != 2'b00) begin
                n_cmp++; if (resp_rdata !== exp_rdata) begin n_fail++; $display("FAIL b2b_rdata c%0d: got %h want %h", k, resp_rdata, exp_rdata); end
            end
            model_commit();
            @(negedge clock);
        end
    endtask

    task automatic test_masked_write();
        for (int k = 0; k < 3; k++) begin
            set_idle();
            case (k)
                0:       set_req(0, 1'b1, 6'd5, ALL1, MASK27);
                1:       set_req(0, 1'b0, 6'd5, '0, '0);
                default: ;
            endcase
            model_eval();
            #1;
            n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL mask_ready c%0d: got %b want %b", k, req_ready, exp_ready); end
            if (k == 0) begin
                n_cmp++;
                if (sram_CEN !== 1'b0 || sram_WEN !== 1'b0 || sram_A !== 6'd5 || sram_BWEN !== ~MASK27 || sram_D !== ALL1) begin
                    n_fail++; $display("FAIL mask_pins: got cen=%b wen=%b a=%0d bwen=%h want 0,0,5,%h", sram_CEN, sram_WEN, sram_A, sram_BWEN, ~MASK27);
                end
            end
            if (k == 2) begin
                n_cmp++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL mask_rvalid: got %b want 01", resp_valid); end
                n_cmp++; if (resp_rdata !== MASK27) begin n_fail++; $display("FAIL mask_rdata: got %h want %h", resp_rdata, MASK27); end
            end
            model_commit();
            @(negedge clock);
        end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 8; k++) begin
            set_idle();
            case (k)
                0:          set_req(0, 1'b1, 6'd7, D1234, ALL1);
                1:          set_req(1, 1'b0, 6'd7, '0, '0);
                2, 3, 4: begin
                    set_req(0, 1'b0, 6'd0, '0, '0);
                    resp_ready = 2'b01;
                end
                5, 6:       set_req(0, 1'b0, 6'd0, '0, '0);
                default: ;
            endcase
            model_eval();
            #1;
            n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL hold_ready c%0d: got %b want %b", k, req_ready, exp_ready); end
            n_cmp++; if (resp_valid !== exp_rvalid) begin n_fail++; $display("FAIL hold_rvalid c%0d: got %b want %b", k, resp_valid, exp_rvalid); end
            if (k >= 2 && k <= 5) begin
                n_cmp++;
                if (resp_valid !== 2'b10 || resp_rdata !== D1234 || req_ready !== 2'b00) begin
                    n_fail++; $display("FAIL hold_data c%0d: got v=%b d=%h r=%b want 10 %h 00", k, resp_valid, resp_rdata, req_ready, D1234);
                end
            end
            model_commit();
            @(negedge clock);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 402; k++) begin
            set_idle();
            if (k < 400) begin
                for (int p = 0; p < 2; p++) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(p, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                                {$urandom, $urandom, $urandom, $urandom},
                                {$urandom, $urandom, $urandom, $urandom});
                end
                resp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            end
            model_eval();
            #1;
            n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", k, req_ready, exp_ready); end
            n_cmp++; if (resp_valid !== exp_rvalid) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b want %b", k, resp_valid, exp_rvalid); end
            if (exp_rvalid != 2'b00) begin
                n_cmp++; if (resp_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h want %h", k, resp_rdata, exp_rdata); end
            end
            model_commit();
            @(negedge clock);
        end
    endtask

    task automatic test_reset_in_hold();
        set_idle();
        set_req(1, 1'b0, 6'd7, '0, '0);
        model_eval();
        model_commit();
        @(negedge clock);
        set_idle();
        resp_ready = 2'b00;
        repeat (2) @(negedge clock);
        #1;
        n_cmp++; if (resp_valid !== 2'b10) begin n_fail++; $display("FAIL rih_pre_hold: got %b want 10", resp_valid); end
        @(negedge clock);
        reset = 1'b1;
        req_valid = 2'b11;
        #1;
        n_cmp++; if (resp_valid !== 2'b00 || req_ready !== 2'b00 || sram_CEN !== 1'b1) begin
            n_fail++; $display("FAIL rih_in_reset: got v=%b r=%b cen=%b want 00 00 1", resp_valid, req_ready, sram_CEN);
        end
        @(negedge clock);
        reset = 1'b0;
        req_valid = 2'b00;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            n_cmp++;
            if (sram_A !== ADDR_W'(k) || sram_CEN !== 1'b0 || sram_WEN !== 1'b0 || resp_valid !== 2'b00) begin
                n_fail++; $display("FAIL rih_refill %0d: got a=%0d cen=%b wen=%b v=%b want %0d 0 0 00", k, sram_A, sram_CEN, sram_WEN, resp_valid, k);
            end
            @(negedge clock);
        end
        model_reset();
        for (int k = 0; k < 2; k++) begin
            set_idle();
            if (k == 0) set_req(1, 1'b0, 6'd7, '0, '0);
            model_eval();
            #1;
            n_cmp++; if (resp_valid !== exp_rvalid) begin n_fail++; $display("FAIL rih_rvalid c%0d: got %b want %b", k, resp_valid, exp_rvalid); end
            if (k == 1) begin
                n_cmp++; if (resp_rdata !== '0) begin n_fail++; $display("FAIL rih_zeroed: got %h want 0", resp_rdata); end
            end
            model_commit();
            @(negedge clock);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_init();
        test_wr_rd_fwd();
        test_back_to_back();
        test_masked_write();
        test_hold();
        test_random();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
